hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Producer of the IF/ID pipeline-register control pair is_stall / is_flush.
//  Detects load-use hazards against the instruction held in IF/ID and taken
//  branches/jumps resolved in EX. Holds each condition for a parameterised
//  number of cycles, and gates PC update and PC redirect in the fetch stage.
// PARAMETERS
//  STALL_CYCLES  `MAX_STALL_COUNT (1..15)  total cycles is_stall stays high per load-use event
//  FLUSH_CYCLES  `MAX_FLUSH_COUNT (1..15)  total cycles is_flush stays high per taken branch
//  CNT_W         16                        width of saturating event/cycle counters
// PORTS
//  clk               in   1      rising-edge clock
//  rst_n             in   1      asynchronous active-low reset
//  if_id_instr       in   32     instr_out of IF/ID (instruction currently in ID)
//  id_ex_mem_read    in   1      instruction in EX is a load
//  id_ex_rd          in   5      destination register of instruction in EX
//  ex_branch_taken   in   1      EX resolved a taken branch or jump this cycle
//  ex_branch_target  in   32     redirect address, valid with ex_branch_taken
//  is_stall          out  1      to IF/ID: hold contents
//  is_flush          out  1      to IF/ID (and ID/EX bubble): zero contents
//  pc_write_en       out  1      fetch PC may advance (= ~is_stall)
//  pc_redirect_vld   out  1      one-cycle pulse: load PC from pc_redirect
//  pc_redirect       out  32     registered copy of ex_branch_target
//  stall_cycles_tot  out  CNT_W  saturating count of cycles with is_stall=1
//  flush_cycles_tot  out  CNT_W  saturating count of cycles with is_flush=1
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, cnt=0, pc_redirect=0, both totals=0; all
//    outputs 0 except pc_write_en=1. Released synchronously to next posedge.
//  - rs-use decode from if_id_instr[6:0]: rs1 used unless LUI/AUIPC/JAL;
//    rs2 used only for R-type, STORE, BRANCH. x0 never a hazard.
//  - load_use = id_ex_mem_read & id_ex_rd!=0 & ((rs1_used & rd==rs1) | (rs2_used & rd==rs2)).
//  - FSM states IDLE, STALL, FLUSH; 4-bit down-counter cnt = extra cycles remaining.
//  - Outputs are Mealy in IDLE (asserted in the detect cycle, zero latency):
//      is_flush = (IDLE & ex_branch_taken) | FLUSH
//      is_stall = (IDLE & load_use & ~ex_branch_taken) | STALL
//  - IDLE: ex_branch_taken -> FLUSH if FLUSH_CYCLES>1, cnt<=FLUSH_CYCLES-1; capture
//    pc_redirect<=ex_branch_target. Else load_use -> STALL if STALL_CYCLES>1,
//    cnt<=STALL_CYCLES-1. Otherwise remain in IDLE.
//  - STALL/FLUSH: cnt decrements each cycle; when cnt==1 -> IDLE next cycle.
//    Total assertion = exactly N cycles for parameter N.
//  - pc_redirect_vld: combinational, high only in the IDLE detect cycle of a taken
//    branch; its address is ex_branch_target in that cycle. pc_redirect holds the
//    captured value for debug.
//  - Branch and load_use in the same cycle: flush wins, no stall issued.
//  - ex_branch_taken while in STALL: abort stall, enter FLUSH (cnt reload,
//    pc_redirect_vld pulses, is_stall drops that cycle).
//  - load_use or ex_branch_taken while in FLUSH: ignored (those instructions are flushed).
//  - is_stall and is_flush are never high in the same cycle.
//  - Totals: +1 per cycle the corresponding output is high; hold at 2^CNT_W-1.
//  - Reset mid-STALL/FLUSH: outputs drop immediately; no residual assertion after release.
// STRUCTURE
//  - defs.v: `MAX_STALL_COUNT, `MAX_FLUSH_COUNT, opcode constants (OP_LOAD, OP_STORE,
//    OP_BRANCH, OP_RTYPE, OP_LUI, OP_AUIPC, OP_JAL), FSM state encodings.
//  - Sub-module hazard_rs_decode (combinational): instr -> rs1, rs2, rs1_used, rs2_used.
//  - Top: FSM, counter, redirect register, two saturating counters.
// TESTING
//  1. EX: lw x5 (mem_read=1, rd=5); ID: add x6,x5,x7 (0x00728333), STALL_CYCLES=1 ->
//     is_stall=1 exactly 1 cycle, pc_write_en=0 that cycle, stall_cycles_tot=1.
//  2. Same hazard with rd=0, and with ID=lui x5 (rs1 unused) -> is_stall never asserts.
//  3. ex_branch_taken=1, target=0x0000_0040, FLUSH_CYCLES=2 -> is_flush high 2 cycles,
//     pc_redirect_vld 1 cycle with 0x40, pc_redirect=0x40 afterwards.
//  4. Load-use and branch in same cycle -> is_flush=1, is_stall=0 throughout.
//  5. STALL_CYCLES=3, branch at 2nd stall cycle -> stall ends, FLUSH_CYCLES flush cycles follow.
//  6. rst_n low in mid-FLUSH -> outputs 0 asynchronously; after release IDLE,
//     totals=0; preload total to 0xFFFE, 3 stall cycles -> total stays 0xFFFF.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: default hold lengths,
// RV32 opcode constants used by the source-register decode, and the FSM
// state encoding.
package hazard_ctrl_pkg;

    // Default number of cycles each condition is held (legal range 1..15).
    localparam int MAX_STALL_COUNT = 1;
    localparam int MAX_FLUSH_COUNT = 2;

    // Width of the hold down-counter; covers the 1..15 parameter range.
    localparam int HOLD_W = 4;

    // RV32 major opcodes (instr[6:0]).
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_rs_decode.sv
// Combinational source-register decode of the instruction held in IF/ID.
// Ports:
//   instr_i     in  32  instruction currently in ID
//   rs1_o       out 5   rs1 field
//   rs2_o       out 5   rs2 field
//   rs1_used_o  out 1   instruction reads rs1 (all but LUI/AUIPC/JAL)
//   rs2_used_o  out 1   instruction reads rs2 (R-type, STORE, BRANCH)
module hazard_rs_decode
    import hazard_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic        rs1_used_o,
    output logic        rs2_used_o
);

    logic [6:0] opcode;
    logic       unused_instr_bits;

    assign opcode = instr_i[6:0];
    assign rs1_o  = instr_i[19:15];
    assign rs2_o  = instr_i[24:20];

    // rd, funct3 and funct7 play no part in hazard detection.
    assign unused_instr_bits = ^{instr_i[31:25], instr_i[14:7]};

    assign rs1_used_o = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    assign rs2_used_o = (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

endmodule

// File: rtl/hazard_ctrl.sv
// IF/ID hazard controller. Raises is_stall on a load-use hazard against the
// instruction in ID and is_flush on a taken branch/jump resolved in EX, each
// for a parameterised number of cycles, and gates the fetch PC accordingly.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   if_id_instr         instruction currently in ID
//   id_ex_mem_read      instruction in EX is a load
//   id_ex_rd            destination register of the instruction in EX
//   ex_branch_taken     EX resolved a taken branch/jump this cycle
//   ex_branch_target    redirect address, valid with ex_branch_taken
//   is_stall / is_flush IF/ID hold / zero controls (never both high)
//   pc_write_en         fetch PC may advance (= ~is_stall)
//   pc_redirect_vld     one-cycle pulse: load PC from ex_branch_target
//   pc_redirect         registered copy of the last accepted target (debug)
//   stall_cycles_tot    saturating count of is_stall cycles
//   flush_cycles_tot    saturating count of is_flush cycles
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int STALL_CYCLES = MAX_STALL_COUNT,
    parameter int FLUSH_CYCLES = MAX_FLUSH_COUNT,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_id_instr,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rd,
    input  logic             ex_branch_taken,
    input  logic [31:0]      ex_branch_target,
    output logic             is_stall,
    output logic             is_flush,
    output logic             pc_write_en,
    output logic             pc_redirect_vld,
    output logic [31:0]      pc_redirect,
    output logic [CNT_W-1:0] stall_cycles_tot,
    output logic [CNT_W-1:0] flush_cycles_tot
);

    localparam logic [HOLD_W-1:0] STALL_RELOAD = HOLD_W'(STALL_CYCLES - 1);
    localparam logic [HOLD_W-1:0] FLUSH_RELOAD = HOLD_W'(FLUSH_CYCLES - 1);

    hz_state_e         state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [31:0]       redirect_q, redirect_d;
    logic [CNT_W-1:0]  stall_tot_q, stall_tot_d;
    logic [CNT_W-1:0]  flush_tot_q, flush_tot_d;

    logic [4:0] rs1, rs2;
    logic       rs1_used, rs2_used;
    logic       load_use;
    logic       branch_accept;

    hazard_rs_decode u_rs_decode (
        .instr_i    (if_id_instr),
        .rs1_o      (rs1),
        .rs2_o      (rs2),
        .rs1_used_o (rs1_used),
        .rs2_used_o (rs2_used)
    );

    // rd==0 excludes x0 for both operands at once.
    assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                      ((rs1_used && id_ex_rd == rs1) || (rs2_used && id_ex_rd == rs2));

    // A branch is honoured from IDLE and also aborts a stall; during FLUSH the
    // branching instruction is itself being squashed, so it is ignored.
    assign branch_accept = ex_branch_taken && (state_q != ST_FLUSH);

    // Mealy outputs: asserted in the detect cycle with zero latency.
    assign is_flush        = branch_accept || (state_q == ST_FLUSH);
    assign is_stall        = !ex_branch_taken &&
                             (((state_q == ST_IDLE) && load_use) || (state_q == ST_STALL));
    assign pc_write_en     = !is_stall;
    assign pc_redirect_vld = branch_accept;
    assign pc_redirect     = redirect_q;

    assign stall_cycles_tot = stall_tot_q;
    assign flush_cycles_tot = flush_tot_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        cnt_d      = cnt_q;
        redirect_d = redirect_q;

        if (branch_accept) begin
            redirect_d = ex_branch_target;
            if (FLUSH_CYCLES > 1) begin
                state_d = ST_FLUSH;
                cnt_d   = FLUSH_RELOAD;
            end else begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (load_use && STALL_CYCLES > 1) begin
                        state_d = ST_STALL;
                        cnt_d   = STALL_RELOAD;
                    end
                end
                ST_STALL, ST_FLUSH: begin
                    // cnt counts the extra cycles still owed after this one.
                    if (cnt_q <= HOLD_W'(1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - HOLD_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        stall_tot_d = (is_stall && stall_tot_q != '1) ? stall_tot_q + CNT_W'(1) : stall_tot_q;
        flush_tot_d = (is_flush && flush_tot_q != '1) ? flush_tot_q + CNT_W'(1) : flush_tot_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            redirect_q  <= '0;
            stall_tot_q <= '0;
            flush_tot_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            redirect_q  <= redirect_d;
            stall_tot_q <= stall_tot_d;
            flush_tot_q <= flush_tot_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
`timescale 1ns/1ps
// Directed bench for hazard_ctrl. Two instances share the stimulus:
// u_a uses STALL_CYCLES=3 / FLUSH_CYCLES=2, u_b uses STALL_CYCLES=1 / FLUSH_CYCLES=2.
module tb_hazard_ctrl;

    localparam int CNT_W = 16;

    // Instructions in ID
    localparam logic [31:0] I_ADD_X5_X7 = 32'h0072_8333; // add x6,x5,x7 (rs1=5)
    localparam logic [31:0] I_ADD_X7_X5 = 32'h0053_8333; // add x6,x7,x5 (rs2=5)
    localparam logic [31:0] I_LUI_RS5   = 32'h0002_80B7; // lui x1,0x28 (rs1 field=5, unused)
    localparam logic [31:0] I_ADDI_RS5  = 32'h0050_0313; // addi x6,x0,5 (rs2 field=5, unused)

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_id_instr;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rd;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;

    logic             a_stall, a_flush, a_pcwe, a_vld;
    logic [31:0]      a_redir;
    logic [CNT_W-1:0] a_stot, a_ftot;
    logic             b_stall, b_flush, b_pcwe, b_vld;
    logic [31:0]      b_redir;
    logic [CNT_W-1:0] b_stot, b_ftot;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) u_a (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_id_instr      (if_id_instr),
        .id_ex_mem_read   (id_ex_mem_read),
        .id_ex_rd         (id_ex_rd),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .is_stall         (a_stall),
        .is_flush         (a_flush),
        .pc_write_en      (a_pcwe),
        .pc_redirect_vld  (a_vld),
        .pc_redirect      (a_redir),
        .stall_cycles_tot (a_stot),
        .flush_cycles_tot (a_ftot)
    );

    hazard_ctrl #(.STALL_CYCLES(1), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) u_b (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_id_instr      (if_id_instr),
        .id_ex_mem_read   (id_ex_mem_read),
        .id_ex_rd         (id_ex_rd),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .is_stall         (b_stall),
        .is_flush         (b_flush),
        .pc_write_en      (b_pcwe),
        .pc_redirect_vld  (b_vld),
        .pc_redirect      (b_redir),
        .stall_cycles_tot (b_stot),
        .flush_cycles_tot (b_ftot)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; returns 2 ns after the rising edge, away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic mr, input logic [4:0] rd, input logic [31:0] instr,
                         input logic bt, input logic [31:0] tgt);
        id_ex_mem_read   = mr;
        id_ex_rd         = rd;
        if_id_instr      = instr;
        ex_branch_taken  = bt;
        ex_branch_target = tgt;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0000_0013, 1'b0, 32'h0);

        // Reset state
        check("rst_a_stall", 32'(a_stall), 32'd0);
        check("rst_a_flush", 32'(a_flush), 32'd0);
        check("rst_a_pcwe",  32'(a_pcwe),  32'd1);
        check("rst_a_vld",   32'(a_vld),   32'd0);
        check("rst_a_redir", a_redir,      32'd0);
        check("rst_b_stot",  32'(b_stot),  32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1: load-use on rs1, one stall cycle on u_b, three on u_a
        drive(1'b1, 5'd5, I_ADD_X5_X7, 1'b0, 32'h0);
        check("t1_b_stall", 32'(b_stall), 32'd1);
        check("t1_b_pcwe",  32'(b_pcwe),  32'd0);
        check("t1_a_stall", 32'(a_stall), 32'd1);
        tick();
        drive(1'b0, 5'd0, I_ADD_X5_X7, 1'b0, 32'h0);
        check("t1_b_stall_end", 32'(b_stall), 32'd0);
        check("t1_b_pcwe_end",  32'(b_pcwe),  32'd1);
        check("t1_b_stot",      32'(b_stot),  32'd1);
        check("t1_a_stall_c2",  32'(a_stall), 32'd1);
        tick();
        check("t1_a_stall_c3",  32'(a_stall), 32'd1);
        tick();
        check("t1_a_stall_end", 32'(a_stall), 32'd0);
        check("t1_a_stot",      32'(a_stot),  32'd3);

        // 2: no hazard for rd=0 or unused source fields; then rs2 hazard
        drive(1'b1, 5'd0, I_ADD_X5_X7, 1'b0, 32'h0);
        check("t2_rd0", 32'(a_stall), 32'd0);
        tick();
        drive(1'b1, 5'd5, I_LUI_RS5, 1'b0, 32'h0);
        check("t2_lui", 32'(a_stall), 32'd0);
        tick();
        drive(1'b1, 5'd5, I_ADDI_RS5, 1'b0, 32'h0);
        check("t2_addi_rs2", 32'(a_stall), 32'd0);
        tick();
        drive(1'b1, 5'd5, I_ADD_X7_X5, 1'b0, 32'h0);
        check("t2_rs2_b", 32'(b_stall), 32'd1);
        check("t2_rs2_a", 32'(a_stall), 32'd1);
        tick();
        drive(1'b0, 5'd0, I_ADD_X7_X5, 1'b0, 32'h0);
        tick();
        tick();
        check("t2_a_idle", 32'(a_stall), 32'd0);
        check("t2_a_stot", 32'(a_stot),  32'd6);
        check("t2_b_stot", 32'(b_stot),  32'd2);

        // 3: taken branch, two flush cycles, one redirect pulse
        drive(1'b0, 5'd0, 32'h0000_0013, 1'b1, 32'h0000_0040);
        check("t3_flush_c1", 32'(a_flush), 32'd1);
        check("t3_vld_c1",   32'(a_vld),   32'd1);
        check("t3_stall_c1", 32'(a_stall), 32'd0);
        check("t3_redir_c1", a_redir,      32'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0000_0013, 1'b0, 32'h0000_0099);
        check("t3_flush_c2", 32'(a_flush), 32'd1);
        check("t3_vld_c2",   32'(a_vld),   32'd0);
        check("t3_redir_c2", a_redir,      32'h0000_0040);
        tick();
        check("t3_flush_end", 32'(a_flush), 32'd0);
        check("t3_ftot",      32'(a_ftot),  32'd2);
        check("t3_redir_hold", a_redir,     32'h0000_0040);

        // 4: load-use and branch together: flush wins
        drive(1'b1, 5'd5, I_ADD_X5_X7, 1'b1, 32'h0000_0080);
        check("t4_a_flush", 32'(a_flush), 32'd1);
        check("t4_a_stall", 32'(a_stall), 32'd0);
        check("t4_b_stall", 32'(b_stall), 32'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0000_0013, 1'b0, 32'h0);
        check("t4_a_flush_c2", 32'(a_flush), 32'd1);
        check("t4_a_stall_c2", 32'(a_stall), 32'd0);
        tick();
        check("t4_a_flush_end", 32'(a_flush), 32'd0);
        check("t4_a_stot", 32'(a_stot), 32'd6);
        check("t4_a_ftot", 32'(a_ftot), 32'd4);

        // 5: branch during second stall cycle aborts the stall
        drive(1'b1, 5'd5, I_ADD_X5_X7, 1'b0, 32'h0);
        check("t5_stall_c1", 32'(a_stall), 32'd1);
        tick();
        drive(1'b0, 5'd0, 32'h0000_0013, 1'b1, 32'h0000_0100);
        check("t5_abort_stall", 32'(a_stall), 32'd0);
        check("t5_abort_flush", 32'(a_flush), 32'd1);
        check("t5_abort_vld",   32'(a_vld),   32'd1);
        check("t5_abort_pcwe",  32'(a_pcwe),  32'd1);
        tick();
        drive(1'b0, 5'd0, 32'h0000_0013, 1'b0, 32'h0);
        check("t5_flush_c2", 32'(a_flush), 32'd1);
        check("t5_stall_c2", 32'(a_stall), 32'd0);
        check("t5_redir",    a_redir,      32'h0000_0100);
        tick();
        check("t5_flush_end", 32'(a_flush), 32'd0);
        check("t5_stall_end", 32'(a_stall), 32'd0);
        check("t5_a_stot", 32'(a_stot), 32'd7);
        check("t5_a_ftot", 32'(a_ftot), 32'd6);

        // 6: reset in mid-flush
        drive(1'b0, 5'd0, 32'h0000_0013, 1'b1, 32'h0000_0200);
        tick();
        drive(1'b0, 5'd0, 32'h0000_0013, 1'b0, 32'h0);
        check("t6_in_flush", 32'(a_flush), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_flush", 32'(a_flush), 32'd0);
        check("t6_rst_stall", 32'(a_stall), 32'd0);
        check("t6_rst_pcwe",  32'(a_pcwe),  32'd1);
        check("t6_rst_ftot",  32'(a_ftot),  32'd0);
        check("t6_rst_stot",  32'(a_stot),  32'd0);
        check("t6_rst_redir", a_redir,      32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_post_flush", 32'(a_flush), 32'd0);
        check("t6_post_ftot",  32'(a_ftot),  32'd0);

        // Saturation: continuous load-use stalls every cycle on both instances
        drive(1'b1, 5'd5, I_ADD_X5_X7, 1'b0, 32'h0);
        repeat (65534) tick();
        check("sat_b_fffe", 32'(b_stot), 32'h0000_FFFE);
        check("sat_a_fffe", 32'(a_stot), 32'h0000_FFFE);
        repeat (3) tick();
        check("sat_b_ffff", 32'(b_stot), 32'h0000_FFFF);
        check("sat_a_ffff", 32'(a_stot), 32'h0000_FFFF);
        drive(1'b0, 5'd0, 32'h0000_0013, 1'b0, 32'h0);
        repeat (3) tick();
        check("sat_hold", 32'(a_stot), 32'h0000_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
